// File: rtl/eth_pkg.sv
// Shared constants, the framing FSM state type and the MAC swap helper for the
// Ethernet packet responder.
package eth_pkg;

   localparam int unsigned DATA_W  = 512;
   localparam int unsigned EMPTY_W = 6;
   localparam int unsigned MAC_W   = 48;
   // MSB positions of the destination and source MAC fields (byte 0 is data[511:504])
   localparam int unsigned DMAC_HI = 511;
   localparam int unsigned SMAC_HI = 463;
   // An SOP&EOP beat with more invalid bytes than this holds fewer than 12 bytes
   localparam logic [EMPTY_W-1:0] RUNT_EMPTY = 6'd52;

   typedef enum logic [1:0] {StIdle, StInPkt, StDrop} state_t;

   // Exchange the destination and source MAC fields; all other bits unchanged.
   function automatic logic [DATA_W-1:0] swap_macs(input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] r;
      r = d;
      r[DMAC_HI -: MAC_W] = d[SMAC_HI -: MAC_W];
      r[SMAC_HI -: MAC_W] = d[DMAC_HI -: MAC_W];
      return r;
   endfunction

endpackage

// File: rtl/avst_skid_buf.sv
// Avalon-ST output register plus one-entry skid buffer.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_data/in_valid     upstream beat, pushed when in_valid & in_ready
//   in_ready             high whenever the skid entry is empty
//   out_data/out_valid   registered downstream beat, held stable while stalled
//   out_ready            downstream backpressure, ready latency 0
module avst_skid_buf #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] skid_q;
   logic             out_valid_q;
   logic             skid_valid_q;
   logic             push;

   assign push = in_valid & in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (!out_valid_q || out_ready) begin
         // Output register frees up: refill from the skid first to keep order.
         // in_ready is low whenever the skid is occupied, so no push collides.
         if (skid_valid_q) begin
            out_q        <= skid_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
         end else begin
            out_valid_q <= push;
            if (push) begin
               out_q <= in_data;
            end
         end
      end else if (push) begin
         // Output stalled: park the beat in the skid.
         skid_q       <= in_data;
         skid_valid_q <= 1'b1;
      end
   end

   assign in_ready  = ~skid_valid_q;
   assign out_data  = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: rtl/eth_pkt_responder.sv
// Ethernet packet responder: checks Avalon-ST framing of packets from the RX
// FIFO, drops disabled/malformed traffic, optionally swaps the MAC addresses
// on the SOP beat and forwards the packet to the TX FIFO.
// Ports:
//   fifo_clk, fifo_rst              clock, asynchronous active-high reset
//   en                              enable, sampled on each accepted SOP beat
//   rx_data/valid/sop/eop/empty     Avalon-ST sink, rx_ready back to the RX FIFO
//   tx_data/valid/sop/eop/empty     Avalon-ST source, tx_ready from the TX FIFO
//   rx_pkt_cnt, tx_pkt_cnt          wrapping counts of accepted SOP / emitted EOP beats
//   err_cnt, drop_cnt               saturating counts of framing errors / dropped packets
module eth_pkt_responder
   import eth_pkg::*;
#(
   parameter bit          SWAP_EN = 1'b1,
   parameter int unsigned CNT_W   = 32
) (
   input  logic               fifo_clk,
   input  logic               fifo_rst,
   input  logic               en,
   input  logic [DATA_W-1:0]  rx_data,
   input  logic               rx_valid,
   input  logic               rx_sop,
   input  logic               rx_eop,
   input  logic [EMPTY_W-1:0] rx_empty,
   output logic               rx_ready,
   output logic [DATA_W-1:0]  tx_data,
   output logic               tx_valid,
   output logic               tx_sop,
   output logic               tx_eop,
   output logic [EMPTY_W-1:0] tx_empty,
   input  logic               tx_ready,
   output logic [CNT_W-1:0]   rx_pkt_cnt,
   output logic [CNT_W-1:0]   tx_pkt_cnt,
   output logic [15:0]        err_cnt,
   output logic [15:0]        drop_cnt
);

   localparam int unsigned BEAT_W = DATA_W + EMPTY_W + 2;

   state_t             state_q;
   state_t             state_d;
   logic               accept;
   logic               fwd;
   logic               close_pkt;
   logic               err_ev;
   logic               drop_ev;
   logic               skid_ready;
   logic               beat_sop;
   logic               beat_eop;
   logic [EMPTY_W-1:0] beat_empty;
   logic [DATA_W-1:0]  beat_data;
   logic [BEAT_W-1:0]  beat_out;

   assign rx_ready = skid_ready & ~fifo_rst;
   assign accept   = rx_valid & rx_ready;

   // Classify each accepted beat: forward, close the open packet, or discard.
   always_comb begin
      state_d   = state_q;
      fwd       = 1'b0;
      close_pkt = 1'b0;
      err_ev    = 1'b0;
      drop_ev   = 1'b0;
      if (accept) begin
         unique case (state_q)
            StIdle: begin
               if (!rx_sop) begin
                  err_ev = 1'b1;
                  if (!rx_eop) state_d = StDrop;
               end else if (!en) begin
                  drop_ev = 1'b1;
                  if (!rx_eop) state_d = StDrop;
               end else if (rx_eop && (rx_empty > RUNT_EMPTY)) begin
                  err_ev = 1'b1;
               end else begin
                  fwd = 1'b1;
                  if (!rx_eop) state_d = StInPkt;
               end
            end
            StInPkt: begin
               fwd = 1'b1;
               if (rx_sop) begin
                  // Unexpected SOP terminates the open packet, rest is dropped
                  close_pkt = 1'b1;
                  err_ev    = 1'b1;
                  state_d   = rx_eop ? StIdle : StDrop;
               end else if (rx_eop) begin
                  state_d = StIdle;
               end
            end
            StDrop: begin
               if (rx_eop) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Shape the beat handed to the output stage.
   always_comb begin
      beat_sop   = rx_sop & ~close_pkt;
      beat_eop   = rx_eop | close_pkt;
      beat_empty = (rx_eop && !close_pkt) ? rx_empty : '0;
      beat_data  = (SWAP_EN && beat_sop) ? swap_macs(rx_data) : rx_data;
   end

   always_ff @(posedge fifo_clk or posedge fifo_rst) begin
      if (fifo_rst) begin
         state_q    <= StIdle;
         rx_pkt_cnt <= '0;
         tx_pkt_cnt <= '0;
         err_cnt    <= '0;
         drop_cnt   <= '0;
      end else begin
         state_q <= state_d;
         if (accept && rx_sop) rx_pkt_cnt <= rx_pkt_cnt + CNT_W'(1);
         if (tx_valid && tx_ready && tx_eop) tx_pkt_cnt <= tx_pkt_cnt + CNT_W'(1);
         if (err_ev && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
         if (drop_ev && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   avst_skid_buf #(
      .WIDTH(BEAT_W)
   ) u_skid (
      .clk      (fifo_clk),
      .rst      (fifo_rst),
      .in_data  ({beat_sop, beat_eop, beat_empty, beat_data}),
      .in_valid (fwd),
      .in_ready (skid_ready),
      .out_data (beat_out),
      .out_valid(tx_valid),
      .out_ready(tx_ready)
   );

   assign {tx_sop, tx_eop, tx_empty, tx_data} = beat_out;

endmodule

// File: tb/tb_eth_pkt_responder.sv
module tb_eth_pkt_responder;

   logic         fifo_clk = 1'b0;
   logic         fifo_rst = 1'b1;
   logic         en       = 1'b1;
   logic [511:0] rx_data  = '0;
   logic         rx_valid = 1'b0;
   logic         rx_sop   = 1'b0;
   logic         rx_eop   = 1'b0;
   logic [5:0]   rx_empty = '0;
   logic         rx_ready;
   logic [511:0] tx_data;
   logic         tx_valid;
   logic         tx_sop;
   logic         tx_eop;
   logic [5:0]   tx_empty;
   logic         tx_ready = 1'b1;
   logic [31:0]  rx_pkt_cnt;
   logic [31:0]  tx_pkt_cnt;
   logic [15:0]  err_cnt;
   logic [15:0]  drop_cnt;

   int total = 0;
   int bad   = 0;
   int rdy_mode = 0;  // 0: always ready, 1: 30% ready, 2: never ready

   always #5 fifo_clk = ~fifo_clk;

   eth_pkt_responder #(
      .SWAP_EN(1'b1),
      .CNT_W  (32)
   ) dut (
      .fifo_clk  (fifo_clk),
      .fifo_rst  (fifo_rst),
      .en        (en),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_sop    (rx_sop),
      .rx_eop    (rx_eop),
      .rx_empty  (rx_empty),
      .rx_ready  (rx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_sop    (tx_sop),
      .tx_eop    (tx_eop),
      .tx_empty  (tx_empty),
      .tx_ready  (tx_ready),
      .rx_pkt_cnt(rx_pkt_cnt),
      .tx_pkt_cnt(tx_pkt_cnt),
      .err_cnt   (err_cnt),
      .drop_cnt  (drop_cnt)
   );

   task automatic chk(input string name, input logic [527:0] act, input logic [527:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic       sop;
      logic       eop;
      logic [5:0] empty;
      logic [511:0] data;
   } beat_t;

   beat_t       exp_q[$];
   bit          m_open;   // a forwarded packet is still open
   bit          m_skip;   // discarding until the next eop
   int unsigned m_rx, m_tx;
   int          m_err, m_drop;

   function automatic logic [511:0] mac_swap(input logic [511:0] d);
      return {d[463:416], d[511:464], d[415:0]};
   endfunction

   task automatic push_exp(input logic s, input logic e, input logic [5:0] emp,
                           input logic [511:0] d);
      beat_t b;
      b.sop = s; b.eop = e; b.empty = emp; b.data = d;
      exp_q.push_back(b);
   endtask

   task automatic model_beat();
      if (rx_sop) m_rx++;
      if (m_skip) begin
         if (rx_eop) m_skip = 0;
      end else if (m_open) begin
         if (rx_sop) begin
            push_exp(1'b0, 1'b1, 6'd0, rx_data);
            if (m_err < 65535) m_err++;
            m_open = 0;
            m_skip = !rx_eop;
         end else begin
            push_exp(1'b0, rx_eop, rx_eop ? rx_empty : 6'd0, rx_data);
            if (rx_eop) m_open = 0;
         end
      end else begin
         if (!rx_sop) begin
            if (m_err < 65535) m_err++;
            m_skip = !rx_eop;
         end else if (!en) begin
            if (m_drop < 65535) m_drop++;
            m_skip = !rx_eop;
         end else if (rx_eop && rx_empty > 6'd52) begin
            if (m_err < 65535) m_err++;
         end else begin
            push_exp(1'b1, rx_eop, rx_eop ? rx_empty : 6'd0, mac_swap(rx_data));
            m_open = !rx_eop;
         end
      end
   endtask

   // Compare process: outputs are stable at the falling edge.
   logic [527:0] prev_tx;
   bit           prev_stall = 0;
   always @(negedge fifo_clk) begin
      logic [527:0] cur_tx;
      beat_t        e;
      cur_tx = 528'({tx_valid, tx_sop, tx_eop, tx_empty, tx_data});
      if (fifo_rst) begin
         exp_q.delete();
         m_open = 0; m_skip = 0;
         m_rx = 0; m_tx = 0; m_err = 0; m_drop = 0;
         prev_stall = 0;
      end else begin
         chk("rx_pkt_cnt", 528'(rx_pkt_cnt), 528'(m_rx));
         chk("tx_pkt_cnt", 528'(tx_pkt_cnt), 528'(m_tx));
         chk("err_cnt", 528'(err_cnt), 528'(m_err));
         chk("drop_cnt", 528'(drop_cnt), 528'(m_drop));
         chk("rx_ready_vs_buffered", 528'(rx_ready), 528'(exp_q.size() < 2));
         chk("tx_valid_vs_buffered", 528'(tx_valid), 528'(exp_q.size() != 0));
         if (prev_stall) chk("stall_hold", cur_tx, prev_tx);
         if (tx_valid && tx_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("tx_beat", 528'({tx_sop, tx_eop, tx_empty, tx_data}), 528'(e));
            if (tx_eop) m_tx++;
         end
         if (rx_valid && rx_ready) model_beat();
         prev_stall = tx_valid && !tx_ready;
         prev_tx    = cur_tx;
      end
   end

   // tx_ready driver
   initial begin
      forever begin
         @(posedge fifo_clk);
         #1;
         case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(0, 99) < 30);
            default: tx_ready = 1'b0;
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge fifo_clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_beat(input logic [511:0] d, input logic s, input logic e,
                            input logic [5:0] emp);
      int  n;
      bit  took;
      n = 0;
      took = 0;
      rx_data = d; rx_sop = s; rx_eop = e; rx_empty = emp; rx_valid = 1'b1;
      while (!took) begin
         @(negedge fifo_clk);
         took = rx_ready;
         @(posedge fifo_clk);
         #1;
         n++;
         if (!took && n > 300) begin
            total++;
            bad++;
            $display("FAIL send_beat_timeout: got no rx_ready in %0d cycles expected ready", n);
            break;
         end
      end
      rx_valid = 1'b0;
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed and random tests ----------------
   initial begin
      logic [511:0] b0, b1, b2, exp0, d;
      logic [415:0] fill;

      // Reset state
      #2;
      chk("rst_rx_ready", 528'(rx_ready), 528'(0));
      chk("rst_tx_valid", 528'(tx_valid), 528'(0));
      chk("rst_rx_pkt_cnt", 528'(rx_pkt_cnt), 528'(0));
      @(posedge fifo_clk);
      @(posedge fifo_clk);
      #1;
      fifo_rst = 1'b0;
      @(negedge fifo_clk);
      chk("ready_after_reset", 528'(rx_ready), 528'(1));
      @(posedge fifo_clk);
      #1;

      // 3-beat packet with MAC swap
      fill = {13{32'hDEADBEEF}};
      b0   = {48'h001122334455, 48'h66778899AABB, fill};
      exp0 = {48'h66778899AABB, 48'h001122334455, fill};
      b1   = {16{32'hA5A50001}};
      b2   = {16{32'h5A5A0002}};
      send_beat(b0, 1'b1, 1'b0, 6'd0);
      chk("t1_b0_valid", 528'(tx_valid), 528'(1));
      chk("t1_b0_sop", 528'(tx_sop), 528'(1));
      chk("t1_b0_data", 528'(tx_data), 528'(exp0));
      send_beat(b1, 1'b0, 1'b0, 6'd0);
      chk("t1_b1_data", 528'(tx_data), 528'(b1));
      chk("t1_b1_sop_eop", 528'({tx_sop, tx_eop}), 528'(2'b00));
      send_beat(b2, 1'b0, 1'b1, 6'd10);
      chk("t1_b2_data", 528'(tx_data), 528'(b2));
      chk("t1_b2_eop_empty", 528'({tx_eop, tx_empty}), 528'({1'b1, 6'd10}));
      idle(1);
      chk("t1_tx_pkt_cnt", 528'(tx_pkt_cnt), 528'(1));
      chk("t1_tx_idle", 528'(tx_valid), 528'(0));

      // Runt boundary: empty 53 dropped, empty 52 forwarded
      send_beat(b1, 1'b1, 1'b1, 6'd53);
      chk("runt53_dropped", 528'(tx_valid), 528'(0));
      chk("runt53_err", 528'(err_cnt), 528'(1));
      send_beat(b1, 1'b1, 1'b1, 6'd52);
      chk("runt52_fwd", 528'({tx_valid, tx_sop, tx_eop, tx_empty}), 528'({3'b111, 6'd52}));
      chk("runt52_err", 528'(err_cnt), 528'(1));

      // SOP inside an open packet
      send_beat(b0, 1'b1, 1'b0, 6'd0);
      send_beat(b1, 1'b0, 1'b0, 6'd0);
      send_beat(b2, 1'b1, 1'b0, 6'd7);
      chk("close_beat", 528'({tx_valid, tx_sop, tx_eop, tx_empty}), 528'({3'b101, 6'd0}));
      chk("close_data", 528'(tx_data), 528'(b2));
      chk("close_err", 528'(err_cnt), 528'(2));
      send_beat(b1, 1'b0, 1'b0, 6'd0);
      chk("drop_mid", 528'(tx_valid), 528'(0));
      send_beat(b1, 1'b0, 1'b1, 6'd3);
      chk("drop_eop", 528'(tx_valid), 528'(0));
      send_beat(b0, 1'b1, 1'b1, 6'd0);
      chk("next_sop_fwd", 528'({tx_valid, tx_sop}), 528'(2'b11));
      chk("next_sop_err", 528'(err_cnt), 528'(2));

      // Disabled responder drops two packets, third forwarded
      en = 1'b0;
      for (int p = 0; p < 2; p++) begin
         send_beat(b0, 1'b1, 1'b0, 6'd0);
         send_beat(b1, 1'b0, 1'b0, 6'd0);
         send_beat(b2, 1'b0, 1'b1, 6'd0);
      end
      chk("en0_drop_cnt", 528'(drop_cnt), 528'(2));
      chk("en0_no_tx", 528'(tx_valid), 528'(0));
      en = 1'b1;
      send_beat(b0, 1'b1, 1'b0, 6'd0);
      chk("en1_fwd", 528'({tx_valid, tx_sop}), 528'(2'b11));
      send_beat(b2, 1'b0, 1'b1, 6'd0);
      idle(2);
      chk("pkt_cnt_after_directed", 528'(tx_pkt_cnt), 528'(5));

      // Random packets under 30% tx_ready
      rdy_mode = 1;
      for (int p = 0; p < 400; p++) begin
         int kind, len;
         kind = $urandom_range(0, 99);
         len  = $urandom_range(1, 24);
         if (kind >= 18 && kind < 23) len = 1;
         en = (kind >= 8);
         for (int i = 0; i < len; i++) begin
            logic       s, e;
            logic [5:0] emp;
            s = (i == 0) ? !(kind >= 8 && kind < 13)
                         : (kind >= 13 && kind < 18 && i == len / 2);
            e = (i == len - 1);
            emp = (kind >= 18 && kind < 23) ? 6'($urandom_range(53, 63))
                                            : 6'($urandom_range(0, 63));
            if ($urandom_range(0, 4) == 0) idle(1);
            send_beat(rand512(), s, e, emp);
         end
      end
      en = 1'b1;
      rdy_mode = 0;
      idle(10);

      // Reset mid-packet with the output stalled
      rdy_mode = 2;
      idle(2);
      send_beat(b0, 1'b1, 1'b0, 6'd0);
      send_beat(b1, 1'b0, 1'b0, 6'd0);
      chk("stalled_full_valid", 528'(tx_valid), 528'(1));
      chk("stalled_full_ready", 528'(rx_ready), 528'(0));
      #2;
      fifo_rst = 1'b1;
      #1;
      chk("async_rst_tx_valid", 528'(tx_valid), 528'(0));
      chk("async_rst_rx_ready", 528'(rx_ready), 528'(0));
      chk("async_rst_cnt", 528'({rx_pkt_cnt, err_cnt}), 528'(0));
      @(posedge fifo_clk);
      @(posedge fifo_clk);
      #1;
      fifo_rst = 1'b0;
      rdy_mode = 0;
      @(negedge fifo_clk);
      chk("ready_after_midrst", 528'(rx_ready), 528'(1));
      @(posedge fifo_clk);
      #1;
      send_beat(b0, 1'b1, 1'b0, 6'd0);
      chk("post_rst_data", 528'(tx_data), 528'(exp0));
      send_beat(b2, 1'b0, 1'b1, 6'd5);
      idle(3);
      chk("post_rst_tx_cnt", 528'(tx_pkt_cnt), 528'(1));
      chk("post_rst_rx_cnt", 528'(rx_pkt_cnt), 528'(1));

      // err_cnt saturation
      fifo_rst = 1'b1;
      idle(1);
      fifo_rst = 1'b0;
      idle(1);
      d = b1;
      for (int i = 0; i < 65540; i++) send_beat(d, 1'b0, 1'b1, 6'd0);
      idle(1);
      chk("err_saturate", 528'(err_cnt), 528'(16'hFFFF));
      chk("err_sat_no_tx", 528'(tx_pkt_cnt), 528'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
